mhs_src_ctrl: RTL
=================

MHS_SRC_CTRL -- requirements
Module: mhs_src_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, payload width.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, buffer entries, power of 2, >=2.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 255, max WAIT cycles before abort, 1..65535.
REQ-004 SHALL have parameter GAP_CYC, default 2, idle cycles after each transfer, 1..255.
REQ-005 SHALL have port clk  input  1  single clock; all logic posedge clk.
REQ-006 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port wr_en  input  1  push request.
REQ-008 SHALL have port wr_data  input  DATA_WIDTH  push payload.
REQ-009 SHALL have port full  output  1  FIFO full, registered.
REQ-010 SHALL have port empty  output  1  FIFO empty, registered.
REQ-011 SHALL have port vld_out  output  1  one-cycle transfer strobe toward handshake source side.
REQ-012 SHALL have port dout  output  DATA_WIDTH  payload, valid with vld_out.
REQ-013 SHALL have port rdy_in  input  1  completion pulse from handshake source side.
REQ-014 SHALL have port busy  output  1  FSM not in IDLE.
REQ-015 SHALL have port err_clr  input  1  clears sticky error flags.
REQ-016 SHALL have port err_timeout  output  1  sticky, a transfer was aborted.
REQ-017 SHALL have port err_ovf  output  1  sticky, a push was dropped.
REQ-018 SHALL have port tx_cnt  output  16  count of completed transfers.

Function
REQ-019 SHALL implement a FIFO_DEPTH-entry FIFO; push when wr_en & !full; full/empty reflect registered occupancy.
REQ-020 SHALL drop wr_en while full, even if a pop occurs that cycle, and set err_ovf next cycle.
REQ-021 SHALL implement FSM states IDLE, SEND, WAIT, GAP; busy = (state != IDLE).
REQ-022 IDLE: if !empty -> SEND, popping head into dout register on that transition; else stay.
REQ-023 SEND: vld_out=1 for exactly this one cycle, dout = popped word; -> WAIT unconditionally.
REQ-024 WAIT: 16-bit wait counter starts at 0, increments each cycle; rdy_in=1 -> GAP and tx_cnt+1; counter reaching TIMEOUT_CYC with rdy_in=0 -> GAP, err_timeout set, tx_cnt unchanged.
REQ-025 rdy_in and timeout in same cycle: rdy_in wins (success, no error).
REQ-026 rdy_in SHALL be ignored in IDLE, SEND, GAP.
REQ-027 GAP: stay GAP_CYC cycles, then -> IDLE; no vld_out within GAP_CYC+2 cycles of previous vld_out end.
REQ-028 Latency: word pushed into empty FIFO in cycle N with FSM in IDLE -> vld_out high in cycle N+2.
REQ-029 dout SHALL hold last transmitted value between transfers.
REQ-030 tx_cnt SHALL wrap 0xFFFF -> 0x0000.
REQ-031 err_clr SHALL clear both sticky flags next cycle; simultaneous set and err_clr -> set wins.
REQ-032 vld_out, busy, full, empty, errors, tx_cnt SHALL all be registered outputs.

Reset
REQ-033 On rstn low: state IDLE, FIFO pointers 0, empty=1, full=0, vld_out=0, dout=0, busy=0, err_timeout=0, err_ovf=0, tx_cnt=0, counters 0.
REQ-034 Reset mid-transfer SHALL discard FIFO contents and in-flight word; no vld_out for at least 2 cycles after rstn release.

Verification
REQ-035 Push 0x1234 into empty FIFO at cycle N, rdy_in pulse 3 cycles after vld_out -> vld_out at N+2 with dout=0x1234, tx_cnt=1, busy low GAP_CYC+1 cycles after rdy_in.
REQ-036 Push 5 words back-to-back, FIFO_DEPTH=4, no pop in between -> 4 accepted, 5th dropped, err_ovf=1, full=1; four vld_out strobes in order, each spaced by rdy_in+GAP.
REQ-037 No rdy_in after vld_out, TIMEOUT_CYC=8 -> err_timeout=1 after 8 WAIT cycles, tx_cnt unchanged, next word sent normally; err_clr -> err_timeout=0.
REQ-038 rdy_in coincident with timeout cycle -> tx_cnt+1, err_timeout stays 0.
REQ-039 Preload tx_cnt to 0xFFFF via 65535 transfers (or force) then one transfer -> tx_cnt=0x0000.
REQ-040 Assert rstn low during WAIT with 2 words queued -> all outputs at reset values, empty=1, no vld_out afterward until new push.

Source files
------------

// File: rtl/mhs_src_ctrl.sv
// mhs_src_ctrl: buffers pushed words in a small FIFO and sends them one at a
// time as single-cycle strobes. After each strobe it waits for a completion
// pulse (or gives up after TIMEOUT_CYC cycles), then idles for GAP_CYC cycles
// before the next word may go out.
module mhs_src_ctrl #(
    parameter int DATA_WIDTH  = 16,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255,
    parameter int GAP_CYC     = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  empty,
    output logic                  vld_out,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  rdy_in,
    output logic                  busy,
    input  logic                  err_clr,
    output logic                  err_timeout,
    output logic                  err_ovf,
    output logic [15:0]           tx_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(FIFO_DEPTH);
    localparam logic [15:0]   WAIT_LAST = 16'(TIMEOUT_CYC - 1);
    localparam logic [7:0]    GAP_LAST  = 8'(GAP_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]         count_q, count_d;
    logic                  full_q, empty_q;
    logic                  vld_q, busy_q;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  err_timeout_q, err_ovf_q;
    logic [15:0]           tx_cnt_q;
    logic [15:0]           wait_q, wait_d;
    logic [7:0]            gap_q, gap_d;
    logic                  push, pop, drop, tx_done, tx_abort;

    // A push is refused whenever the registered full flag is set, even if a pop frees a slot this cycle.
    assign push = wr_en & ~full_q;
    assign drop = wr_en & full_q;

    // Next-state logic of the transfer sequencer; the pop happens on the IDLE->SEND transition.
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        gap_d    = gap_q;
        pop      = 1'b0;
        tx_done  = 1'b0;
        tx_abort = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty_q) begin
                    state_d = S_SEND;
                    pop     = 1'b1;
                end
            end
            S_SEND: begin
                state_d = S_WAIT;
                wait_d  = '0;
            end
            S_WAIT: begin
                if (rdy_in) begin
                    state_d = S_GAP;
                    tx_done = 1'b1;
                    gap_d   = '0;
                end else if (wait_q == WAIT_LAST) begin
                    state_d  = S_GAP;
                    tx_abort = 1'b1;
                    gap_d    = '0;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Occupancy after this cycle's push and pop, used to register full/empty.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (!push && pop) begin
            count_d = count_q - CW'(1);
        end
    end

    // FIFO storage needs no reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    // All control state and every output flag are registered here.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= S_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            full_q        <= 1'b0;
            empty_q       <= 1'b1;
            vld_q         <= 1'b0;
            busy_q        <= 1'b0;
            dout_q        <= '0;
            err_timeout_q <= 1'b0;
            err_ovf_q     <= 1'b0;
            tx_cnt_q      <= '0;
            wait_q        <= '0;
            gap_q         <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            gap_q   <= gap_d;
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_CNT);
            empty_q <= (count_d == '0);
            vld_q   <= (state_d == S_SEND);
            busy_q  <= (state_d != S_IDLE);
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
                dout_q   <= mem[rd_ptr_q];
            end
            if (tx_done) begin
                tx_cnt_q <= tx_cnt_q + 16'd1;
            end
            if (tx_abort) begin
                err_timeout_q <= 1'b1;
            end else if (err_clr) begin
                err_timeout_q <= 1'b0;
            end
            if (drop) begin
                err_ovf_q <= 1'b1;
            end else if (err_clr) begin
                err_ovf_q <= 1'b0;
            end
        end
    end

    assign full        = full_q;
    assign empty       = empty_q;
    assign vld_out     = vld_q;
    assign dout        = dout_q;
    assign busy        = busy_q;
    assign err_timeout = err_timeout_q;
    assign err_ovf     = err_ovf_q;
    assign tx_cnt      = tx_cnt_q;

endmodule
